// File: rtl/alu_exec_unit_if.sv
// Issue, CDB and control bundle between the reservation station / CDB arbiter
// (master) and alu_exec_unit (slave); dbg_* expose internal state.
interface alu_exec_unit_if #(
    parameter int ROB_IDX_W = 4,
    parameter int OP_W      = 6
) ();
    // Handshake: issue fires when issue_valid && alu_ready at a rising edge;
    // the queue head pops when alu_broadcast (cdb_req && cdb_grant && rdy).
    logic                 rdy;
    logic                 clr;
    logic                 issue_valid;
    logic [OP_W-1:0]      issue_op;
    logic [31:0]          issue_rs1;
    logic [31:0]          issue_rs2;
    logic [31:0]          issue_imm;
    logic [31:0]          issue_pc;
    logic [ROB_IDX_W-1:0] issue_rd_rename;
    logic                 alu_ready;
    logic                 cdb_req;
    logic                 cdb_grant;
    logic                 alu_broadcast;
    logic [31:0]          alu_cbd_value;
    logic [ROB_IDX_W-1:0] alu_update_rename;
    logic                 alu_jump;
    logic [31:0]          alu_target;
    logic [1:0]           dbg_count;
    logic [1:0]           dbg_mul_state;

    modport master (
        output rdy, clr, issue_valid, issue_op, issue_rs1, issue_rs2, issue_imm,
               issue_pc, issue_rd_rename, cdb_grant,
        input  alu_ready, cdb_req, alu_broadcast, alu_cbd_value, alu_update_rename,
               alu_jump, alu_target, dbg_count, dbg_mul_state
    );

    modport slave (
        input  rdy, clr, issue_valid, issue_op, issue_rs1, issue_rs2, issue_imm,
               issue_pc, issue_rd_rename, cdb_grant,
        output alu_ready, cdb_req, alu_broadcast, alu_cbd_value, alu_update_rename,
               alu_jump, alu_target, dbg_count, dbg_mul_state
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Integer execution unit: single-cycle ALU/branch ops into a 2-entry CDB queue.
// Define ALU_MUL_EN to build the 3-cycle OP_MUL FSM; otherwise OP_MUL is undefined.
module alu_exec_unit #(
    parameter int ROB_IDX_W = 4,
    parameter int OP_W      = 6
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(27);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(28);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(29);

    logic                 w_is_imm;
    logic [31:0]          w_op2;
    logic [31:0]          w_pc_imm;
    logic [31:0]          w_value;
    logic [31:0]          w_target;
    logic                 w_jump;
    logic                 w_req;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue_push;
    logic                 w_wr_idx;
    logic [31:0]          w_push_val;
    logic [ROB_IDX_W-1:0] w_push_ren;
    logic                 w_push_jmp;
    logic [31:0]          w_push_tgt;
    logic                 w_mul_idle;
    logic                 w_mul_start;
    logic                 w_mul_push;
    logic [31:0]          w_mul_val;
    logic [ROB_IDX_W-1:0] w_mul_ren;

    logic [1:0]           r_count;
    logic [31:0]          r_q_val [2];
    logic [ROB_IDX_W-1:0] r_q_ren [2];
    logic                 r_q_jmp [2];
    logic [31:0]          r_q_tgt [2];

    assign w_is_imm = bus.issue_op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
                                           OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI};
    assign w_op2    = w_is_imm ? bus.issue_imm : bus.issue_rs2;
    assign w_pc_imm = bus.issue_pc + bus.issue_imm;

    always_comb begin
        w_value  = 32'd0;
        w_jump   = 1'b0;
        w_target = 32'd0;
        case (bus.issue_op)
            OP_LUI:   w_value = bus.issue_imm;
            OP_AUIPC: w_value = w_pc_imm;
            OP_JAL: begin
                w_value  = bus.issue_pc + 32'd4;
                w_target = w_pc_imm;
                w_jump   = 1'b1;
            end
            OP_JALR: begin
                w_value  = bus.issue_pc + 32'd4;
                w_target = (bus.issue_rs1 + bus.issue_imm) & ~32'd1;
                w_jump   = 1'b1;
            end
            OP_BEQ:  begin w_target = w_pc_imm; w_jump = (bus.issue_rs1 == bus.issue_rs2); end
            OP_BNE:  begin w_target = w_pc_imm; w_jump = (bus.issue_rs1 != bus.issue_rs2); end
            OP_BLT:  begin w_target = w_pc_imm; w_jump = ($signed(bus.issue_rs1) <  $signed(bus.issue_rs2)); end
            OP_BGE:  begin w_target = w_pc_imm; w_jump = ($signed(bus.issue_rs1) >= $signed(bus.issue_rs2)); end
            OP_BLTU: begin w_target = w_pc_imm; w_jump = (bus.issue_rs1 <  bus.issue_rs2); end
            OP_BGEU: begin w_target = w_pc_imm; w_jump = (bus.issue_rs1 >= bus.issue_rs2); end
            OP_ADD,  OP_ADDI:  w_value = bus.issue_rs1 + w_op2;
            OP_SUB:            w_value = bus.issue_rs1 - bus.issue_rs2;
            OP_SLT,  OP_SLTI:  w_value = {31'd0, $signed(bus.issue_rs1) < $signed(w_op2)};
            OP_SLTU, OP_SLTIU: w_value = {31'd0, bus.issue_rs1 < w_op2};
            OP_XOR,  OP_XORI:  w_value = bus.issue_rs1 ^ w_op2;
            OP_OR,   OP_ORI:   w_value = bus.issue_rs1 | w_op2;
            OP_AND,  OP_ANDI:  w_value = bus.issue_rs1 & w_op2;
            OP_SLL,  OP_SLLI:  w_value = bus.issue_rs1 << w_op2[4:0];
            OP_SRL,  OP_SRLI:  w_value = bus.issue_rs1 >> w_op2[4:0];
            OP_SRA,  OP_SRAI:  w_value = $unsigned($signed(bus.issue_rs1) >>> w_op2[4:0]);
            default: ;
        endcase
    end

    // Readiness depends only on registered state and control inputs, never on cdb_grant.
    assign w_req    = (r_count != 2'd0);
    assign w_ready  = !rst && bus.rdy && !bus.clr && (r_count < 2'd2) && w_mul_idle;
    assign w_accept = bus.issue_valid && w_ready;
    assign w_pop    = w_req && bus.cdb_grant && bus.rdy;

    assign w_issue_push = w_accept && !w_mul_start;
    assign w_push       = w_issue_push || w_mul_push;
    assign w_push_val   = w_mul_push ? w_mul_val : w_value;
    assign w_push_ren   = w_mul_push ? w_mul_ren : bus.issue_rd_rename;
    assign w_push_jmp   = w_mul_push ? 1'b0 : w_jump;
    assign w_push_tgt   = w_mul_push ? 32'd0 : w_target;
    // Slot 0 is always the head; a simultaneous pop shifts the new entry down.
    assign w_wr_idx     = (r_count == 2'd1) && !w_pop;

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_count <= 2'd0;
        end else if (bus.rdy) begin
            if (w_pop) begin
                r_q_val[0] <= r_q_val[1];
                r_q_ren[0] <= r_q_ren[1];
                r_q_jmp[0] <= r_q_jmp[1];
                r_q_tgt[0] <= r_q_tgt[1];
            end
            if (w_push) begin
                r_q_val[w_wr_idx] <= w_push_val;
                r_q_ren[w_wr_idx] <= w_push_ren;
                r_q_jmp[w_wr_idx] <= w_push_jmp;
                r_q_tgt[w_wr_idx] <= w_push_tgt;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef ALU_MUL_EN
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(30);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_M1   = 2'd1,
        S_M2   = 2'd2
    } mul_state_e;

    mul_state_e           r_mul_state;
    mul_state_e           w_mul_next;
    logic [31:0]          r_mul_a;
    logic [31:0]          r_mul_b;
    logic [31:0]          r_mul_p;
    logic [ROB_IDX_W-1:0] r_mul_ren;

    assign w_mul_start = w_accept && (bus.issue_op == OP_MUL);
    assign w_mul_idle  = (r_mul_state == S_IDLE);
    assign w_mul_val   = r_mul_p;
    assign w_mul_ren   = r_mul_ren;

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_mul_state <= S_IDLE;
        end else if (bus.rdy) begin
            r_mul_state <= w_mul_next;
        end
        if (bus.rdy && w_mul_start) begin
            r_mul_a   <= bus.issue_rs1;
            r_mul_b   <= bus.issue_rs2;
            r_mul_ren <= bus.issue_rd_rename;
        end
        if (bus.rdy && r_mul_state == S_M1) begin
            r_mul_p <= r_mul_a * r_mul_b;
        end
    end

    // M2 holds its product until the queue has a free slot.
    always_comb begin
        w_mul_next = r_mul_state;
        w_mul_push = 1'b0;
        case (r_mul_state)
            S_IDLE: if (w_mul_start) w_mul_next = S_M1;
            S_M1:   w_mul_next = S_M2;
            S_M2: begin
                if (r_count < 2'd2) begin
                    w_mul_push = 1'b1;
                    w_mul_next = S_IDLE;
                end
            end
            default: w_mul_next = S_IDLE;
        endcase
    end

    assign bus.dbg_mul_state = r_mul_state;
`else
    assign w_mul_start       = 1'b0;
    assign w_mul_idle        = 1'b1;
    assign w_mul_push        = 1'b0;
    assign w_mul_val         = 32'd0;
    assign w_mul_ren         = '0;
    assign bus.dbg_mul_state = 2'd0;
`endif

    assign bus.alu_ready         = w_ready;
    assign bus.cdb_req           = w_req;
    assign bus.alu_broadcast     = w_pop;
    assign bus.alu_cbd_value     = w_req ? r_q_val[0] : 32'd0;
    assign bus.alu_update_rename = w_req ? r_q_ren[0] : '0;
    assign bus.alu_jump          = w_req ? r_q_jmp[0] : 1'b0;
    assign bus.alu_target        = w_req ? r_q_tgt[0] : 32'd0;
    assign bus.dbg_count         = r_count;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios plus randomized traffic against a
// transaction-level model (result function + expected-entry queue).
module tb_alu_exec_unit;
    localparam logic [5:0] OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3, OP_JALR = 6'd4;
    localparam logic [5:0] OP_BEQ = 6'd5, OP_BNE = 6'd6, OP_BLT = 6'd7, OP_BGE = 6'd8;
    localparam logic [5:0] OP_BLTU = 6'd9, OP_BGEU = 6'd10, OP_ADDI = 6'd11, OP_SLTI = 6'd12;
    localparam logic [5:0] OP_SLTIU = 6'd13, OP_XORI = 6'd14, OP_ORI = 6'd15, OP_ANDI = 6'd16;
    localparam logic [5:0] OP_SLLI = 6'd17, OP_SRLI = 6'd18, OP_SRAI = 6'd19, OP_ADD = 6'd20;
    localparam logic [5:0] OP_SUB = 6'd21, OP_SLL = 6'd22, OP_SLT = 6'd23, OP_SLTU = 6'd24;
    localparam logic [5:0] OP_XOR = 6'd25, OP_SRL = 6'd26, OP_SRA = 6'd27, OP_OR = 6'd28;
    localparam logic [5:0] OP_AND = 6'd29, OP_MUL = 6'd30;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] v;
        logic [3:0]  r;
        logic        j;
        logic [31:0] t;
    } ent_t;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;
    ent_t exp_q[$];
    int   m_phase;
    ent_t m_mul;

    alu_exec_unit_if #(.ROB_IDX_W(4), .OP_W(6)) bus ();
    alu_exec_unit #(.ROB_IDX_W(4), .OP_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of one instruction, computed with 64-bit arithmetic then truncated.
    function automatic ent_t ref_exec(input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                                      input logic [3:0] tag);
        ent_t e;
        logic [31:0] y;
        longint sa, sb, sy;
        int sh;
        e = '0;
        e.r = tag;
        y = (op >= OP_ADDI && op <= OP_SRAI) ? imm : b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sy = longint'($signed(y));
        sh = int'(y % 32);
        case (op)
            OP_LUI:   e.v = imm;
            OP_AUIPC: e.v = 32'(longint'(pc) + longint'(imm));
            OP_JAL:   begin e.v = pc + 32'd4; e.t = 32'(longint'(pc) + longint'(imm)); e.j = 1'b1; end
            OP_JALR:  begin e.v = pc + 32'd4; e.t = 32'(longint'(a) + longint'(imm)); e.t[0] = 1'b0; e.j = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                e.t = 32'(longint'(pc) + longint'(imm));
                case (op)
                    OP_BEQ:  e.j = (a == b);
                    OP_BNE:  e.j = (a != b);
                    OP_BLT:  e.j = (sa < sb);
                    OP_BGE:  e.j = !(sa < sb);
                    OP_BLTU: e.j = (longint'(a) < longint'(b));
                    default: e.j = !(longint'(a) < longint'(b));
                endcase
            end
            OP_ADD, OP_ADDI:   e.v = 32'(longint'(a) + longint'(y));
            OP_SUB:            e.v = 32'(longint'(a) - longint'(b));
            OP_SLT, OP_SLTI:   e.v = (sa < sy) ? 32'd1 : 32'd0;
            OP_SLTU, OP_SLTIU: e.v = (longint'(a) < longint'(y)) ? 32'd1 : 32'd0;
            OP_XOR, OP_XORI:   e.v = a ^ y;
            OP_OR, OP_ORI:     e.v = a | y;
            OP_AND, OP_ANDI:   e.v = a & y;
            OP_SLL, OP_SLLI:   e.v = 32'(longint'(a) << sh);
            OP_SRL, OP_SRLI:   e.v = 32'(longint'(a) >> sh);
            OP_SRA, OP_SRAI:   e.v = 32'(sa >>> sh);
            OP_MUL:            e.v = MUL_EN ? 32'(longint'(a) * longint'(b)) : 32'd0;
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit model_ready();
        return !rst && bus.rdy && !bus.clr && exp_q.size() < 2 && m_phase == 0;
    endfunction

    // Advance the model by one edge using the inputs present at that edge.
    task automatic model_update();
        bit acc, pop, mpush;
        ent_t e;
        if (rst || bus.clr) begin
            exp_q.delete();
            m_phase = 0;
        end else if (bus.rdy) begin
            acc   = bus.issue_valid && model_ready();
            pop   = exp_q.size() != 0 && bus.cdb_grant;
            mpush = m_phase == 2 && exp_q.size() < 2;
            e = ref_exec(bus.issue_op, bus.issue_rs1, bus.issue_rs2, bus.issue_imm,
                         bus.issue_pc, bus.issue_rd_rename);
            if (pop) void'(exp_q.pop_front());
            if (mpush) begin exp_q.push_back(m_mul); m_phase = 0; end
            else if (m_phase == 1) m_phase = 2;
            if (acc) begin
                if (MUL_EN && bus.issue_op == OP_MUL) begin m_mul = e; m_phase = 1; end
                else exp_q.push_back(e);
            end
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_issue(input logic v, input logic [5:0] op, input logic [31:0] a, b,
                               imm, pc, input logic [3:0] tag);
        bus.issue_valid = v; bus.issue_op = op; bus.issue_rs1 = a; bus.issue_rs2 = b;
        bus.issue_imm = imm; bus.issue_pc = pc; bus.issue_rd_rename = tag;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clock_edge();
        @(negedge clk);
        n_run++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %0b exp 0", bus.alu_ready); end
        n_run++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0b exp 0", bus.cdb_req); end
        clock_edge();
        rst = 1'b0;
        @(negedge clk);
        n_run++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %0b exp 1", bus.alu_ready); end
        n_run++; if (bus.alu_cbd_value !== 32'd0) begin n_fail++; $display("FAIL post_rst_value got %h exp 0", bus.alu_cbd_value); end
        n_run++; if (bus.alu_broadcast !== 1'b0 || bus.alu_jump !== 1'b0 || bus.alu_target !== 32'd0)
            begin n_fail++; $display("FAIL post_rst_outs got bc=%0b j=%0b t=%h exp 0", bus.alu_broadcast, bus.alu_jump, bus.alu_target); end
        n_run++; if (bus.dbg_mul_state !== 2'd0) begin n_fail++; $display("FAIL post_rst_mul got %0d exp 0", bus.dbg_mul_state); end
        clock_edge();
    endtask

    task automatic test_add();
        bus.cdb_grant = 1'b1;
        drive_issue(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 4'd5);
        clock_edge();
        drive_issue(1'b0, 6'd0, 0, 0, 0, 0, 4'd0);
        @(negedge clk);
        n_run++; if (bus.alu_broadcast !== 1'b1) begin n_fail++; $display("FAIL add_bcast got %0b exp 1", bus.alu_broadcast); end
        n_run++; if (bus.alu_cbd_value !== 32'h1) begin n_fail++; $display("FAIL add_value got %h exp 00000001", bus.alu_cbd_value); end
        n_run++; if (bus.alu_update_rename !== 4'd5) begin n_fail++; $display("FAIL add_rename got %0d exp 5", bus.alu_update_rename); end
        n_run++; if (bus.alu_jump !== 1'b0) begin n_fail++; $display("FAIL add_jump got %0b exp 0", bus.alu_jump); end
        clock_edge();
    endtask

    task automatic test_branch();
        bus.cdb_grant = 1'b1;
        drive_issue(1'b1, OP_BLT, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 4'd1);
        clock_edge();
        drive_issue(1'b1, OP_BLTU, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 4'd2);
        @(negedge clk);
        n_run++; if (bus.alu_jump !== 1'b1) begin n_fail++; $display("FAIL blt_jump got %0b exp 1", bus.alu_jump); end
        n_run++; if (bus.alu_target !== 32'h120) begin n_fail++; $display("FAIL blt_target got %h exp 00000120", bus.alu_target); end
        n_run++; if (bus.alu_cbd_value !== 32'd0) begin n_fail++; $display("FAIL blt_value got %h exp 0", bus.alu_cbd_value); end
        clock_edge();
        drive_issue(1'b0, 6'd0, 0, 0, 0, 0, 4'd0);
        @(negedge clk);
        n_run++; if (bus.alu_update_rename !== 4'd2 || bus.alu_jump !== 1'b0)
            begin n_fail++; $display("FAIL bltu_jump got tag=%0d j=%0b exp tag=2 j=0", bus.alu_update_rename, bus.alu_jump); end
        n_run++; if (bus.alu_target !== 32'h120) begin n_fail++; $display("FAIL bltu_target got %h exp 00000120", bus.alu_target); end
        clock_edge();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ex_ready [6];
        logic [3:0]  ex_tag [6];
        ex_ready = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2};
        ex_tag   = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3};
        bus.cdb_grant = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c >= 3) bus.cdb_grant = 1'b1;
            if (c < 2) drive_issue(1'b1, OP_ADD, 32'(c * 16), 32'd3, 0, 0, 4'(c + 1));
            else if (c < 5) drive_issue(1'b1, OP_ADD, 32'd100, 32'd3, 0, 0, 4'd3);
            else drive_issue(1'b0, 6'd0, 0, 0, 0, 0, 4'd0);
            @(negedge clk);
            if (ex_ready[c] != 2'd2) begin
                n_run++; if (bus.alu_ready !== ex_ready[c][0])
                    begin n_fail++; $display("FAIL b2b_ready c=%0d got %0b exp %0b", c, bus.alu_ready, ex_ready[c][0]); end
            end
            if (c >= 3) begin
                n_run++; if (bus.alu_broadcast !== 1'b1 || bus.alu_update_rename !== ex_tag[c])
                    begin n_fail++; $display("FAIL b2b_order c=%0d got bc=%0b tag=%0d exp bc=1 tag=%0d", c, bus.alu_broadcast, bus.alu_update_rename, ex_tag[c]); end
            end
            clock_edge();
        end
        @(negedge clk);
        n_run++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %0b exp 0", bus.cdb_req); end
    endtask

    task automatic test_clr();
        bus.cdb_grant = 1'b0;
        drive_issue(1'b1, OP_ADD, 32'd1, 32'd1, 0, 0, 4'd7);
        clock_edge();
        drive_issue(1'b1, OP_ADD, 32'd2, 32'd2, 0, 0, 4'd8);
        clock_edge();
        bus.clr = 1'b1;
        drive_issue(1'b1, OP_ADD, 32'd3, 32'd3, 0, 0, 4'd9);
        @(negedge clk);
        n_run++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready got %0b exp 0", bus.alu_ready); end
        clock_edge();
        bus.clr = 1'b0;
        bus.cdb_grant = 1'b1;
        drive_issue(1'b0, 6'd0, 0, 0, 0, 0, 4'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_run++; if (bus.cdb_req !== 1'b0 || bus.alu_broadcast !== 1'b0 || bus.alu_cbd_value !== 32'd0)
                begin n_fail++; $display("FAIL clr_flush c=%0d got req=%0b bc=%0b v=%h exp 0", c, bus.cdb_req, bus.alu_broadcast, bus.alu_cbd_value); end
            clock_edge();
        end
    endtask

    task automatic test_rdy_low();
        bus.cdb_grant = 1'b0;
        drive_issue(1'b1, OP_ADD, 32'd10, 32'd20, 0, 0, 4'd4);
        clock_edge();
        bus.rdy = 1'b0;
        bus.cdb_grant = 1'b1;
        drive_issue(1'b1, OP_ADD, 32'd1, 32'd1, 0, 0, 4'd6);
        @(negedge clk);
        n_run++; if (bus.alu_ready !== 1'b0 || bus.alu_broadcast !== 1'b0)
            begin n_fail++; $display("FAIL rdy_freeze got ready=%0b bc=%0b exp 0 0", bus.alu_ready, bus.alu_broadcast); end
        n_run++; if (bus.alu_cbd_value !== 32'd30) begin n_fail++; $display("FAIL rdy_hold got %h exp 0000001e", bus.alu_cbd_value); end
        clock_edge();
        bus.rdy = 1'b1;
        drive_issue(1'b0, 6'd0, 0, 0, 0, 0, 4'd0);
        @(negedge clk);
        n_run++; if (bus.alu_broadcast !== 1'b1 || bus.alu_update_rename !== 4'd4 || bus.dbg_count !== 2'd1)
            begin n_fail++; $display("FAIL rdy_resume got bc=%0b tag=%0d cnt=%0d exp 1 4 1", bus.alu_broadcast, bus.alu_update_rename, bus.dbg_count); end
        clock_edge();
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        bus.cdb_grant = 1'b1;
        drive_issue(1'b1, OP_MUL, 32'h1_0000, 32'h1_0000, 0, 0, 4'd3);
        clock_edge();
        drive_issue(1'b1, OP_ADD, 32'd1, 32'd1, 0, 0, 4'd9);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_run++; if (bus.alu_ready !== 1'b0 || bus.dbg_mul_state !== 2'(c) || bus.cdb_req !== 1'b0)
                begin n_fail++; $display("FAIL mul_busy N+%0d got rdy=%0b st=%0d req=%0b exp 0 %0d 0", c, bus.alu_ready, bus.dbg_mul_state, bus.cdb_req, c); end
            clock_edge();
            if (c == 2) drive_issue(1'b0, 6'd0, 0, 0, 0, 0, 4'd0);
        end
        @(negedge clk);
        n_run++; if (bus.alu_broadcast !== 1'b1 || bus.alu_cbd_value !== 32'd0 || bus.alu_update_rename !== 4'd3)
            begin n_fail++; $display("FAIL mul_result got bc=%0b v=%h tag=%0d exp 1 0 3", bus.alu_broadcast, bus.alu_cbd_value, bus.alu_update_rename); end
        clock_edge();
        drive_issue(1'b1, OP_MUL, 32'd3, 32'd5, 0, 0, 4'd2);
        clock_edge();
        drive_issue(1'b0, 6'd0, 0, 0, 0, 0, 4'd0);
        bus.clr = 1'b1;
        clock_edge();
        bus.clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_run++; if (bus.dbg_mul_state !== 2'd0 || bus.alu_broadcast !== 1'b0)
                begin n_fail++; $display("FAIL mul_clr c=%0d got st=%0d bc=%0b exp 0 0", c, bus.dbg_mul_state, bus.alu_broadcast); end
            clock_edge();
        end
    endtask
`else
    task automatic test_mul();
        bus.cdb_grant = 1'b1;
        drive_issue(1'b1, OP_MUL, 32'd3, 32'd5, 32'd8, 32'd4, 4'd2);
        clock_edge();
        drive_issue(1'b0, 6'd0, 0, 0, 0, 0, 4'd0);
        @(negedge clk);
        n_run++; if (bus.alu_broadcast !== 1'b1 || bus.alu_cbd_value !== 32'd0 || bus.alu_jump !== 1'b0 || bus.alu_target !== 32'd0)
            begin n_fail++; $display("FAIL mul_undef got bc=%0b v=%h j=%0b t=%h exp 1 0 0 0", bus.alu_broadcast, bus.alu_cbd_value, bus.alu_jump, bus.alu_target); end
        clock_edge();
    endtask
`endif

    task automatic test_random();
        ent_t h;
        bit   e_req;
        for (int c = 0; c < 500; c++) begin
            bus.rdy       = ($urandom_range(0, 9) != 0);
            bus.clr       = ($urandom_range(0, 39) == 0);
            bus.cdb_grant = ($urandom_range(0, 3) != 0);
            drive_issue($urandom_range(0, 3) != 0, 6'($urandom_range(0, 33)), rand_word(),
                        rand_word(), rand_word(), rand_word(), 4'($urandom_range(0, 15)));
            @(negedge clk);
            e_req = exp_q.size() != 0;
            h = e_req ? exp_q[0] : '0;
            n_run++; if (bus.alu_ready !== model_ready()) begin n_fail++; $display("FAIL rnd_ready c=%0d got %0b exp %0b", c, bus.alu_ready, model_ready()); end
            n_run++; if (bus.cdb_req !== e_req) begin n_fail++; $display("FAIL rnd_req c=%0d got %0b exp %0b", c, bus.cdb_req, e_req); end
            n_run++; if (bus.dbg_count !== 2'(exp_q.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, bus.dbg_count, exp_q.size()); end
            n_run++; if (bus.alu_broadcast !== (e_req && bus.cdb_grant && bus.rdy))
                begin n_fail++; $display("FAIL rnd_bcast c=%0d got %0b", c, bus.alu_broadcast); end
            n_run++; if (bus.alu_cbd_value !== h.v || bus.alu_update_rename !== h.r)
                begin n_fail++; $display("FAIL rnd_head c=%0d got v=%h tag=%0d exp v=%h tag=%0d", c, bus.alu_cbd_value, bus.alu_update_rename, h.v, h.r); end
            n_run++; if (bus.alu_jump !== h.j || bus.alu_target !== h.t)
                begin n_fail++; $display("FAIL rnd_ctrl c=%0d got j=%0b t=%h exp j=%0b t=%h", c, bus.alu_jump, bus.alu_target, h.j, h.t); end
            clock_edge();
        end
        bus.rdy = 1'b1;
        bus.clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.clr = 1'b1;
        drive_issue(1'b0, 6'd0, 0, 0, 0, 0, 4'd0);
        clock_edge();
        bus.clr = 1'b0;
        bus.cdb_grant = 1'b0;
        drive_issue(1'b1, OP_JAL, 32'd0, 32'd0, 32'h40, 32'h200, 4'd11);
        clock_edge();
        drive_issue(1'b0, 6'd0, 0, 0, 0, 0, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        n_run++; if (bus.alu_target !== 32'h240 || bus.alu_ready !== 1'b0)
            begin n_fail++; $display("FAIL rmid_before got t=%h rdy=%0b exp 00000240 0", bus.alu_target, bus.alu_ready); end
        clock_edge();
        rst = 1'b0;
        @(negedge clk);
        n_run++; if (bus.cdb_req !== 1'b0 || bus.alu_target !== 32'd0 || bus.alu_update_rename !== 4'd0 || bus.alu_jump !== 1'b0)
            begin n_fail++; $display("FAIL rmid_clear got req=%0b t=%h tag=%0d j=%0b exp 0", bus.cdb_req, bus.alu_target, bus.alu_update_rename, bus.alu_jump); end
        clock_edge();
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        m_phase = 0;
        m_mul = '0;
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.clr = 1'b0;
        bus.cdb_grant = 1'b0;
        drive_issue(1'b0, 6'd0, 0, 0, 0, 0, 4'd0);
        test_reset();
        test_add();
        test_branch();
        test_back_to_back();
        test_clr();
        test_rdy_low();
        test_mul();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
